// File: rtl/rtc_pkg.sv
// Shared calendar types, field layout and date rules for the RTC calendar.
// Provides BCD month/weekday constants, the packed date struct and leap/max_day helpers.
package rtc_pkg;

    localparam logic [7:0] MONTH_JAN = 8'h01;
    localparam logic [7:0] MONTH_FEB = 8'h02;
    localparam logic [7:0] MONTH_APR = 8'h04;
    localparam logic [7:0] MONTH_JUN = 8'h06;
    localparam logic [7:0] MONTH_SEP = 8'h09;
    localparam logic [7:0] MONTH_NOV = 8'h11;
    localparam logic [7:0] MONTH_DEC = 8'h12;

    localparam logic [7:0] DAY_FIRST = 8'h01;
    localparam logic [7:0] DAY_LAST_DEC = 8'h31;

    localparam logic [2:0] WD_SUN = 3'd0;
    localparam logic [2:0] WD_SAT = 3'd6;

    localparam int DAY_LSB   = 0;
    localparam int MONTH_LSB = 8;
    localparam int YEAR_LSB  = 16;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
    } bcd_date_t;

    // Divisibility by 4 of a two-digit BCD value, decided from the digits:
    // even tens need units 0/4/8, odd tens need units 2/6.
    function automatic logic bcd_div4(input logic [7:0] x);
        logic [3:0] u;
        u = x[3:0];
        return (!x[4] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
               ( x[4] && (u == 4'd2 || u == 4'd6));
    endfunction

    // Century years fall back to the century digits (the /400 rule).
    function automatic logic is_leap(input logic [15:0] year);
        if (year[7:0] == 8'h00)
            return bcd_div4(year[15:8]);
        return bcd_div4(year[7:0]);
    endfunction

    // Invalid months get 31 so the day counter still rolls over.
    function automatic logic [7:0] max_day(input logic [7:0] month,
                                           input logic       leap);
        if (month == MONTH_FEB)
            return leap ? 8'h29 : 8'h28;
        if (month == MONTH_APR || month == MONTH_JUN ||
            month == MONTH_SEP || month == MONTH_NOV)
            return 8'h30;
        return 8'h31;
    endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// Signal bundle between the RTC time/register side and the calendar stage.
// master drives tick/load inputs and reads the date; slave is the calendar.
interface rtc_calendar_if;
    logic        day_tick_i;
    logic        date_update_i;
    logic [31:0] date_i;
    logic [2:0]  weekday_i;
    logic [31:0] date_o;
    logic [2:0]  weekday_o;
    logic        leap_year_o;
    logic        new_year_o;

    modport master (
        output day_tick_i, date_update_i, date_i, weekday_i,
        input  date_o, weekday_o, leap_year_o, new_year_o
    );

    modport slave (
        input  day_tick_i, date_update_i, date_i, weekday_i,
        output date_o, weekday_o, leap_year_o, new_year_o
    );
endinterface

// File: rtl/rtc_bcd_inc.sv
// Ripple BCD incrementer over DIGITS nibbles.
// value_i/en_i in, value_o (value+en in BCD) and carry_o out; digits >= 9 wrap to 0.
module rtc_bcd_inc #(
    parameter int DIGITS = 2
) (
    input  logic [4*DIGITS-1:0] value_i,
    input  logic                en_i,
    output logic [4*DIGITS-1:0] value_o,
    output logic                carry_o
);

    logic carry;

    always_comb begin
        carry   = en_i;
        value_o = value_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                // >= 9 rather than == 9 so invalid digits cannot stick.
                if (value_i[4*i +: 4] >= 4'd9) begin
                    value_o[4*i +: 4] = 4'd0;
                end else begin
                    value_o[4*i +: 4] = value_i[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        carry_o = carry;
    end

endmodule

// File: rtl/rtc_calendar.sv
// BCD calendar: advances day/month/year and weekday on each day tick.
// Ports: clk_i, rst_i (sync, active-high), bus (slave: tick/load in, date/weekday/leap/new_year out).
module rtc_calendar
    import rtc_pkg::*;
#(
    parameter logic [31:0] RESET_DATE    = 32'h2000_0101,
    parameter logic [2:0]  RESET_WEEKDAY = 3'd6
) (
    input logic           clk_i,
    input logic           rst_i,
    rtc_calendar_if.slave bus
);

    bcd_date_t   date_q, date_d;
    logic [2:0]  weekday_q, weekday_d;

    logic        leap;
    logic        day_end;
    logic        month_end;
    logic [7:0]  day_inc;
    logic [7:0]  month_inc;
    logic [15:0] year_inc;
    logic        day_carry;
    logic        month_carry;
    logic        year_carry;
    logic        unused_carries;

    assign leap      = is_leap(date_q.year);
    assign day_end   = date_q.day >= max_day(date_q.month, leap);
    assign month_end = date_q.month >= MONTH_DEC;

    rtc_bcd_inc #(.DIGITS(2)) u_day_inc (
        .value_i (date_q.day),
        .en_i    (bus.day_tick_i),
        .value_o (day_inc),
        .carry_o (day_carry)
    );

    rtc_bcd_inc #(.DIGITS(2)) u_month_inc (
        .value_i (date_q.month),
        .en_i    (day_end),
        .value_o (month_inc),
        .carry_o (month_carry)
    );

    rtc_bcd_inc #(.DIGITS(4)) u_year_inc (
        .value_i (date_q.year),
        .en_i    (day_end & month_end),
        .value_o (year_inc),
        .carry_o (year_carry)
    );

    // Roll-over is decided by max_day/month compare, and 9999 wraps silently.
    assign unused_carries = day_carry ^ month_carry ^ year_carry;

    always_comb begin
        date_d    = date_q;
        weekday_d = weekday_q;
        if (bus.date_update_i) begin
            date_d    = bus.date_i;
            weekday_d = bus.weekday_i;
        end else if (bus.day_tick_i) begin
            weekday_d = (weekday_q >= WD_SAT) ? WD_SUN : weekday_q + 3'd1;
            if (day_end) begin
                date_d.day = DAY_FIRST;
                if (month_end) begin
                    date_d.month = MONTH_JAN;
                    date_d.year  = year_inc;
                end else begin
                    date_d.month = month_inc;
                end
            end else begin
                date_d.day = day_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            date_q    <= RESET_DATE;
            weekday_q <= RESET_WEEKDAY;
        end else begin
            date_q    <= date_d;
            weekday_q <= weekday_d;
        end
    end

    assign bus.date_o      = date_q;
    assign bus.weekday_o   = weekday_q;
    assign bus.leap_year_o = leap;
    assign bus.new_year_o  = bus.day_tick_i & ~bus.date_update_i &
                             (date_q.month == MONTH_DEC) &
                             (date_q.day == DAY_LAST_DEC);

endmodule

// File: tb/tb_rtc_calendar.sv
// Scoreboard bench for rtc_calendar against an integer calendar model.
// Driver pushes expected per-cycle outputs; negedge monitor pops and compares.
module tb_rtc_calendar;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rtc_calendar_if vif ();

    rtc_calendar u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (vif)
    );

    typedef struct {
        logic [31:0] date;
        logic [2:0]  wd;
        logic        leap;
        logic        ny;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    int my, mm, md, mw;

    function automatic bit leap_of(input int y);
        return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
    endfunction

    function automatic int mdays(input int m, input int y);
        if (m == 2) return leap_of(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [31:0] to_bcd(input int y, input int m, input int d);
        logic [31:0] r;
        r[31:28] = 4'((y / 1000) % 10);
        r[27:24] = 4'((y / 100) % 10);
        r[23:20] = 4'((y / 10) % 10);
        r[19:16] = 4'(y % 10);
        r[15:12] = 4'(m / 10);
        r[11:8]  = 4'(m % 10);
        r[7:4]   = 4'(d / 10);
        r[3:0]   = 4'(d % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("date_o", vif.date_o, e.date);
            check("weekday_o", 32'(vif.weekday_o), 32'(e.wd));
            check("leap_year_o", 32'(vif.leap_year_o), 32'(e.leap));
            check("new_year_o", 32'(vif.new_year_o), 32'(e.ny));
        end
    end

    task automatic drive(input bit r, input bit u, input bit t,
                         input int y, input int m, input int d, input int w);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = r;
        vif.date_update_i = u;
        vif.day_tick_i    = t;
        vif.date_i        = to_bcd(y, m, d);
        vif.weekday_i     = 3'(w);
        e.date = to_bcd(my, mm, md);
        e.wd   = 3'(mw);
        e.leap = leap_of(my);
        e.ny   = t && !u && mm == 12 && md == 31;
        q.push_back(e);
        if (r) begin
            my = 2000; mm = 1; md = 1; mw = 6;
        end else if (u) begin
            my = y; mm = m; md = d; mw = w;
        end else if (t) begin
            mw = (mw >= 6) ? 0 : mw + 1;
            if (md < mdays(mm, my)) begin
                md++;
            end else begin
                md = 1;
                if (mm < 12) begin
                    mm++;
                end else begin
                    mm = 1;
                    my = (my + 1) % 10000;
                end
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic tick();
        drive(0, 0, 1, 0, 1, 1, 0);
    endtask

    task automatic load(input int y, input int m, input int d, input int w);
        drive(0, 1, 0, y, m, d, w);
    endtask

    initial begin
        int sel, y, m, d, w, guard;
        rst               = 1'b1;
        vif.date_update_i = 1'b0;
        vif.day_tick_i    = 1'b0;
        vif.date_i        = '0;
        vif.weekday_i     = '0;
        repeat (2) @(posedge clk);
        my = 2000; mm = 1; md = 1; mw = 6;

        idle();
        tick(); tick(); tick(); idle();

        load(2024, 2, 28, 3); tick(); tick(); idle();
        load(2100, 2, 28, 0); tick(); idle();
        load(2000, 2, 28, 1); tick(); idle();
        load(9999, 12, 31, 5); tick(); idle();

        drive(0, 1, 1, 2023, 4, 30, 0); idle(); tick(); idle();
        drive(1, 1, 1, 2023, 4, 30, 0); idle();

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            y = $urandom_range(0, 9999);
            m = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                m = 12;
                d = 31;
            end else if ($urandom_range(0, 1) == 0) begin
                d = mdays(m, y);
            end else begin
                d = $urandom_range(1, mdays(m, y));
            end
            w = $urandom_range(0, 6);
            if (sel < 3)       drive(1, 0, $urandom_range(0, 1), y, m, d, w);
            else if (sel < 15) load(y, m, d, w);
            else if (sel < 20) drive(0, 1, 1, y, m, d, w);
            else if (sel < 80) tick();
            else               idle();
        end
        idle();

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
